// File: rtl/maxnet_iterator.sv
// Iterative MaxNet engine: holds four activations, applies one lateral-inhibition
// step per cycle, and hands the checker's winner (or an error) downstream.
module maxnet_iterator #(
  parameter int W         = 32,
  parameter int EPS_SHIFT = 3,
  parameter int MAX_ITER  = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x1,
  input  logic [W-1:0] in_x2,
  input  logic [W-1:0] in_x3,
  input  logic [W-1:0] in_x4,
  output logic [W-1:0] x1,
  output logic [W-1:0] x2,
  output logic [W-1:0] x3,
  output logic [W-1:0] x4,
  output logic         o1,
  output logic         o2,
  output logic         o3,
  output logic         o4,
  input  logic         term_done,
  input  logic [W-1:0] term_out,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [W-1:0] result,
  output logic [1:0]   result_idx,
  output logic [7:0]   iter_count,
  output logic         err_zero,
  output logic         err_timeout
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic [7:0] ITER_LIMIT = 8'(MAX_ITER);

  state_t         state_q, state_d;
  logic [W-1:0]   x_q    [4];
  logic [W-1:0]   x_next [4];
  logic [W-1:0]   in_x   [4];
  logic [3:0]     nz;
  logic [1:0]     win_idx;
  logic           all_zero;
  logic           timeout;

  assign in_x = '{in_x1, in_x2, in_x3, in_x4};

  assign x1 = x_q[0];
  assign x2 = x_q[1];
  assign x3 = x_q[2];
  assign x4 = x_q[3];

  always_comb begin
    for (int i = 0; i < 4; i++) nz[i] = |x_q[i];
  end

  assign o1 = nz[0];
  assign o2 = nz[1];
  assign o3 = nz[2];
  assign o4 = nz[3];

  assign all_zero     = ~|nz;
  assign timeout      = (iter_count == ITER_LIMIT);
  assign in_ready     = (state_q == IDLE);
  assign result_valid = (state_q == DONE);

  // Lane of the single nonzero activation; only meaningful when term_done is high.
  always_comb begin
    // NOTE: default first so every path assigns win_idx and no latch is inferred.
    win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (nz[i]) win_idx = 2'(i);
    end
  end

  // Inhibition step: every lane uses the same old values; sums are W+2 bits wide
  // so three full-scale lanes never wrap.
  always_comb begin
    logic [W+1:0] s;
    logic [W+1:0] d;
    for (int i = 0; i < 4; i++) begin
      s = {2'b00, x_q[(i + 1) % 4]} + {2'b00, x_q[(i + 2) % 4]} + {2'b00, x_q[(i + 3) % 4]};
      d = s >> EPS_SHIFT;
      x_next[i] = ({2'b00, x_q[i]} > d) ? (x_q[i] - d[W-1:0]) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = ITER;
      ITER:    if (term_done || all_zero || timeout) state_d = DONE;
      DONE:    if (result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) x_q[i] <= '0;
      result      <= '0;
      result_idx  <= '0;
      iter_count  <= '0;
      err_zero    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 4; i++) x_q[i] <= in_x[i];
            result      <= '0;
            result_idx  <= '0;
            iter_count  <= '0;
            err_zero    <= 1'b0;
            err_timeout <= 1'b0;
          end
        end
        ITER: begin
          if (term_done) begin
            result     <= term_out;
            result_idx <= win_idx;
          end else if (all_zero) begin
            err_zero <= 1'b1;
            result   <= '0;
          end else if (timeout) begin
            err_timeout <= 1'b1;
            result      <= '0;
          end else begin
            for (int i = 0; i < 4; i++) x_q[i] <= x_next[i];
            iter_count <= iter_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
